// File: rtl/fir_mac_sequencer.sv
// Control sequencer for the FIR MAC datapath: zero-fills the circular delay line
// after reset, writes each new sample, issues one tap address pair per clock, then flags the result.
module fir_mac_sequencer #(
  parameter int NUM_TAPS = 317,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic              sample_pulse,
  input  logic [DATA_W-1:0] sample_in,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  output logic [ADDR_W-1:0] coef_raddr,
  output logic              tap_valid,
  output logic              tap_first,
  output logic              result_valid,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WRITE, S_MAC, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(PIPE_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d, wp_q, wp_d, rp_q, rp_d;
  logic              we_q, we_d, tv_q, tv_d, tf_q, tf_d, rv_q, rv_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d, craddr_q, craddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Every *_d output describes the state being entered, so outputs line up with state_q.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    ovr_d    = ovr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    craddr_d = craddr_q;
    tv_d     = 1'b0;
    tf_d     = 1'b0;
    rv_d     = 1'b0;
    busy_d   = 1'b1;
    case (state_q)
      S_CLEAR: begin
        if (sample_pulse) ovr_d = 1'b1;
        // The write-address register doubles as the clear counter.
        if (!we_q) begin
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = '0;
        end else if (waddr_q == LAST_TAP) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + 1'b1;
          wdata_d = '0;
        end
      end
      S_IDLE: begin
        busy_d = 1'b0;
        if (sample_pulse) begin
          state_d = S_WRITE;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          waddr_d = wp_q;
          wdata_d = sample_in;
        end
      end
      S_WRITE: begin
        if (sample_pulse) ovr_d = 1'b1;
        state_d  = S_MAC;
        k_d      = '0;
        rp_d     = wp_q;
        tv_d     = 1'b1;
        tf_d     = 1'b1;
        craddr_d = '0;
        raddr_d  = wp_q;
      end
      S_MAC: begin
        if (sample_pulse) ovr_d = 1'b1;
        if (k_q == LAST_TAP) begin
          state_d = S_DRAIN;
          k_d     = '0;
          wp_d    = (wp_q == LAST_TAP) ? '0 : wp_q + 1'b1;
        end else begin
          k_d      = k_q + 1'b1;
          rp_d     = (rp_q == '0) ? LAST_TAP : rp_q - 1'b1;
          tv_d     = 1'b1;
          craddr_d = k_d;
          raddr_d  = rp_d;
        end
      end
      S_DRAIN: begin
        if (sample_pulse) ovr_d = 1'b1;
        if (k_q == LAST_DRAIN) begin
          state_d = S_DONE;
          rv_d    = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (sample_pulse) begin
          state_d = S_WRITE;
          we_d    = 1'b1;
          waddr_d = wp_q;
          wdata_d = sample_in;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      k_q      <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      ovr_q    <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      raddr_q  <= '0;
      craddr_q <= '0;
      tv_q     <= 1'b0;
      tf_q     <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      ovr_q    <= ovr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
      craddr_q <= craddr_d;
      tv_q     <= tv_d;
      tf_q     <= tf_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
    end
  end

  assign buf_we       = we_q;
  assign buf_waddr    = waddr_q;
  assign buf_wdata    = wdata_q;
  assign buf_raddr    = raddr_q;
  assign coef_raddr   = craddr_q;
  assign tap_valid    = tv_q;
  assign tap_first    = tf_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: a reduced tap count keeps wrap-around within a short run;
// expected addresses and tap data come from a sample-history model of y[n] = sum c[k]*x[n-k].
module tb_fir_mac_sequencer;
  localparam int NT = 23;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int PL = 4;

  logic          clk_fast = 1'b0;
  logic          rst = 1'b1;
  logic          sample_pulse = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          buf_we, tap_valid, tap_first, result_valid, busy, overrun;
  logic [AW-1:0] buf_waddr, buf_raddr, coef_raddr;
  logic [DW-1:0] buf_wdata;

  int checks = 0;
  int failures = 0;

  // Delay-line RAM driven by the DUT's write port; the model predicts what it should hold.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] hist [$];
  int            m_wp;
  bit            m_ovr;

  fir_mac_sequencer #(.NUM_TAPS(NT), .DATA_W(DW), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk_fast(clk_fast), .rst(rst), .sample_pulse(sample_pulse), .sample_in(sample_in),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
    .coef_raddr(coef_raddr), .tap_valid(tap_valid), .tap_first(tap_first),
    .result_valid(result_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk_fast = ~clk_fast;

  always @(posedge clk_fast) if (buf_we) ram[buf_waddr] <= buf_wdata;

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    m_wp  = 0;
    m_ovr = 0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < NT; i++) begin
      tick();
      checks++;
      if ({busy, buf_we, buf_waddr, buf_wdata, tap_valid, result_valid} !==
          {1'b1, 1'b1, AW'(i), DW'(0), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL clear[%0d]: busy=%b we=%b waddr=%0d wdata=%h tv=%b rv=%b, want busy=1 we=1 waddr=%0d wdata=0 tv=0 rv=0",
                 i, busy, buf_we, buf_waddr, buf_wdata, tap_valid, result_valid, i);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || buf_we !== 1'b0) begin
      failures++;
      $display("FAIL clear_end: busy=%b we=%b, want 0 0", busy, buf_we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_pulse = 1'b0;
    tick();
    tick();
    checks++;
    if ({buf_we, busy, tap_valid, tap_first, result_valid, overrun, buf_waddr, buf_raddr, coef_raddr, buf_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: we=%b busy=%b tv=%b tf=%b rv=%b ovr=%b waddr=%0d raddr=%0d craddr=%0d wdata=%h, want all 0",
               buf_we, busy, tap_valid, tap_first, result_valid, overrun, buf_waddr, buf_raddr, coef_raddr, buf_wdata);
    end
    rst = 1'b0;
    model_reset();
    test_clear();
  endtask

  task automatic test_idle(input int n);
    sample_pulse = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if ({busy, buf_we, tap_valid, result_valid, overrun} !== {1'b0, 1'b0, 1'b0, 1'b0, m_ovr}) begin
        failures++;
        $display("FAIL idle: busy=%b we=%b tv=%b rv=%b ovr=%b, want 0 0 0 0 %b",
                 busy, buf_we, tap_valid, result_valid, overrun, m_ovr);
      end
    end
  endtask

  // Caller is in cycle 0 (IDLE or DONE). ovr_n is a cycle in which an extra pulse arrives (-1: none).
  task automatic compute(input logic [DW-1:0] s, input int ovr_n);
    int            k;
    logic [DW-1:0] xk;
    sample_pulse = 1'b1;
    sample_in    = s;
    tick();
    sample_pulse = 1'b0;
    sample_in    = DW'($urandom);
    checks++;
    if ({buf_we, buf_waddr, buf_wdata, busy, tap_valid, result_valid} !==
        {1'b1, AW'(m_wp), s, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL write: we=%b waddr=%0d wdata=%h busy=%b tv=%b rv=%b, want we=1 waddr=%0d wdata=%h busy=1 tv=0 rv=0",
               buf_we, buf_waddr, buf_wdata, busy, tap_valid, result_valid, m_wp, s);
    end
    hist.push_back(s);
    for (int n = 2; n <= NT + PL + 2; n++) begin
      sample_pulse = (n - 1 == ovr_n);
      if (sample_pulse) sample_in = DW'($urandom);
      tick();
      sample_pulse = 1'b0;
      if (n - 1 == ovr_n) m_ovr = 1;
      k = n - 2;
      checks++;
      if (k < NT) begin
        xk = (k < hist.size()) ? hist[hist.size() - 1 - k] : '0;
        if ({tap_valid, tap_first, coef_raddr, buf_raddr} !==
            {1'b1, (k == 0), AW'(k), AW'((m_wp - k + NT) % NT)} || ram[buf_raddr] !== xk) begin
          failures++;
          $display("FAIL tap[%0d]: tv=%b tf=%b craddr=%0d raddr=%0d data=%h, want tv=1 tf=%b craddr=%0d raddr=%0d data=%h",
                   k, tap_valid, tap_first, coef_raddr, buf_raddr, ram[buf_raddr],
                   (k == 0), k, (m_wp - k + NT) % NT, xk);
        end
      end else if ({tap_valid, tap_first, coef_raddr} !== {1'b0, 1'b0, AW'(NT - 1)}) begin
        failures++;
        $display("FAIL drain[%0d]: tv=%b tf=%b craddr=%0d, want tv=0 tf=0 craddr=%0d",
                 n, tap_valid, tap_first, coef_raddr, NT - 1);
      end
      checks++;
      if ({busy, buf_we, result_valid, overrun} !== {1'b1, 1'b0, (n == NT + PL + 2), m_ovr}) begin
        failures++;
        $display("FAIL status[cycle %0d]: busy=%b we=%b rv=%b ovr=%b, want busy=1 we=0 rv=%b ovr=%b",
                 n, busy, buf_we, result_valid, overrun, (n == NT + PL + 2), m_ovr);
      end
    end
    m_wp = (m_wp + 1) % NT;
  endtask

  task automatic test_single();
    test_idle(3);
    compute(16'h1234, -1);
    test_idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) compute(DW'($urandom), -1);
    test_idle(1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i <= NT; i++) begin
      compute(DW'($urandom), -1);
      test_idle($urandom_range(0, 2));
    end
    test_idle(1);
  endtask

  task automatic test_overrun();
    compute(DW'($urandom), 2 + NT / 2);
    test_idle(4);
    compute(DW'($urandom), NT + PL);
    test_idle(3);
  endtask

  task automatic test_mid_reset();
    int kk;
    kk = NT / 2;
    sample_pulse = 1'b1;
    sample_in    = DW'($urandom);
    tick();
    sample_pulse = 1'b0;
    repeat (kk + 1) tick();
    checks++;
    if ({tap_valid, coef_raddr} !== {1'b1, AW'(kk)}) begin
      failures++;
      $display("FAIL mid_mac: tv=%b craddr=%0d, want tv=1 craddr=%0d", tap_valid, coef_raddr, kk);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({buf_we, busy, tap_valid, tap_first, result_valid, overrun, buf_waddr, buf_raddr, coef_raddr, buf_wdata} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: we=%b busy=%b tv=%b tf=%b rv=%b ovr=%b waddr=%0d raddr=%0d craddr=%0d, want all 0",
               buf_we, busy, tap_valid, tap_first, result_valid, overrun, buf_waddr, buf_raddr, coef_raddr);
    end
    rst = 1'b0;
    model_reset();
    test_clear();
    compute(DW'($urandom), -1);
    test_idle(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_overrun();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Control sequencer for the 317-tap FIR datapath.
- On each single-cycle sample pulse from the sample-rate synchroniser, it writes the new sample into a circular delay-line RAM.
- It then issues one (sample address, coefficient address) pair per clock to the DSP48E1 MAC chain, and flags the accumulated result once the DSP pipeline has drained.
- It also zero-fills the delay line after reset, and flags samples that arrive while a computation is still in progress (overrun).

Parameters:
- NUM_TAPS, 317: filter length; delay-line and coefficient depth.
- DATA_W, 16: sample width.
- ADDR_W, 9: address width; must satisfy 2^ADDR_W >= NUM_TAPS.
- PIPE_LAT, 4: cycles from the last tap issue to a valid accumulator output.

Ports:
- clk_fast  in  1  100 MHz system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- sample_pulse  in  1  one-cycle new-sample strobe from the synchroniser.
- sample_in  in  DATA_W  new sample; valid while sample_pulse=1.
- buf_we  out  1  delay-line RAM write enable.
- buf_waddr  out  ADDR_W  delay-line write address.
- buf_wdata  out  DATA_W  delay-line write data.
- buf_raddr  out  ADDR_W  delay-line read address.
- coef_raddr  out  ADDR_W  coefficient ROM read address.
- tap_valid  out  1  a tap pair is issued this cycle; the datapath pipelines it alongside the data.
- tap_first  out  1  first tap of a sample; DSP loads the product instead of accumulating.
- result_valid  out  1  one-cycle strobe: the accumulator holds y[n].
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; set when a sample is dropped.

Behaviour:
- Reset and interface
  - Clock is clk_fast; reset rst is synchronous and active-high.
  - On rst, all outputs go to 0, internal write pointer wp=0, tap counter k=0, and state=CLEAR.
  - rst asserted mid-operation aborts immediately; no result_valid is produced.
- States: CLEAR, IDLE, WRITE, MAC, DRAIN, DONE.
- CLEAR
  - buf_we=1, buf_wdata=0, buf_waddr counts 0..NUM_TAPS-1, one location per cycle; busy=1.
  - After address NUM_TAPS-1 is written, go to IDLE.
  - Lasts exactly NUM_TAPS cycles.
- IDLE
  - busy=0.
  - If sample_pulse=1, capture sample_in and go to WRITE.
- WRITE (1 cycle)
  - buf_we=1, buf_waddr=wp, buf_wdata=captured sample.
  - Go to MAC with k=0 and read pointer rp=wp.
- MAC (NUM_TAPS cycles)
  - tap_valid=1, coef_raddr=k, buf_raddr=rp; tap_first=1 only when k=0.
  - Each cycle: k increments; rp decrements, wrapping from 0 to NUM_TAPS-1. No modulo arithmetic; use a compare-and-reload.
  - The RAM must return the newly written sample on the first MAC read (write-then-read of the same address one cycle later).
  - After k=NUM_TAPS-1: wp advances (NUM_TAPS-1 wraps to 0), then go to DRAIN.
- DRAIN (PIPE_LAT cycles)
  - tap_valid=0; counter expires, then go to DONE.
- DONE (1 cycle)
  - result_valid=1.
  - If sample_pulse=1 in this cycle, capture the sample and go to WRITE; otherwise go to IDLE.
- Latency
  - Counting the IDLE cycle with sample_pulse=1 as cycle 0:
    - WRITE at cycle 1.
    - MAC at cycles 2..NUM_TAPS+1.
    - DRAIN at the next PIPE_LAT cycles.
    - result_valid at cycle NUM_TAPS+PIPE_LAT+2 (323 with defaults).
  - This fits well within the roughly 2083-cycle 48 kHz period.
- Overrun
  - sample_pulse=1 in CLEAR, WRITE, MAC or DRAIN drops the sample and sets overrun=1.
  - overrun is cleared only by rst.
  - The sequence in progress is unaffected.
- Addresses are held at their last values when not in use; outputs are registered.

Test Plan:
- Reset clear: assert rst for 2 cycles, release.
  - busy=1 for exactly 317 cycles; buf_waddr steps 0..316 with buf_we=1 and buf_wdata=0; then busy=0.
- Single sample: after CLEAR, pulse with sample_in=16'h1234.
  - buf_we at addr 0 with data 16'h1234 at cycle 1.
  - 317 tap_valid cycles; tap_first only on the first, with buf_raddr=0, coef_raddr=0.
  - Next issue has buf_raddr=316, coef_raddr=1.
  - result_valid at cycle 323 only.
- Wrap-around: drive 318 pulses spaced 2083 cycles apart.
  - Sample 317 is written at addr 316.
  - Sample 318 is written at addr 0; its tap reads run 0,316,315,...,1.
- Overrun: pulse at cycle 100 of a computation.
  - overrun=1 from the next cycle; tap sequence and result_valid timing unchanged; no extra WRITE.
  - overrun stays 1 until rst.
- Back-to-back: pulse coincident with the DONE cycle.
  - Accepted; WRITE follows DONE directly; overrun remains 0.
- Mid-operation reset: rst at MAC cycle 50.
  - Outputs go to 0 next cycle; no result_valid; CLEAR restarts at addr 0; the next sample is written at addr 0.
